// File: rtl/trig_ctrl_pkg.sv
// Shared definitions for the trigger readout controller: FSM state
// encoding, default ID width, counter widths and a saturating increment.
package trig_ctrl_pkg;

  localparam int ID_WIDTH_DEF = 16;
  localparam int CNT_WIDTH    = 16;
  localparam int DEAD_WIDTH   = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DEAD    = 2'd2,
    ST_FULL    = 2'd3
  } ctrl_state_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/id_fifo.sv
// Small FIFO of captured trigger IDs. Pointers carry one extra bit so a
// full FIFO (same index, different wrap bit) is distinct from an empty one.
// dout is a registered copy of the head entry and reads 0 when empty.
module id_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_ptr_nxt;
  logic [AW:0]      rd_ptr_nxt;
  logic             push_ok;
  logic             pop_ok;
  logic [WIDTH-1:0] head_nxt;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  // A pop on an empty FIFO is dropped; a push into a full FIFO only
  // proceeds when a pop frees a slot in the same cycle.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Next pointers and the entry that will sit at the head after this cycle.
  always_comb begin
    wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, push_ok};
    rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop_ok};
    head_nxt   = '0;
    if (wr_ptr_nxt != rd_ptr_nxt) begin
      if (push_ok && (rd_ptr_nxt == wr_ptr)) begin
        head_nxt = din;
      end else begin
        head_nxt = mem[rd_ptr_nxt[AW-1:0]];
      end
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  // Pointer update and registered head output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      dout   <= head_nxt;
    end
  end

endmodule

// File: rtl/trigger_readout_ctrl.sv
// Trigger readout controller: accepts synchronized trigger pulses, starts
// the ID deserializer, buffers captured IDs for SPI readout, applies an
// optional dead time and vetoes new triggers while it cannot take them.
//
// Handshakes: there is no valid/ready back-pressure anywhere. trig_pulse,
// id_valid, rd_req, clear_counts and capture_start are single-cycle pulses
// that act on the rising edge where they are high; a pulse arriving when
// the block cannot act on it is dropped (triggers are counted as lost).
module trigger_readout_ctrl
  import trig_ctrl_pkg::*;
#(
  parameter int ID_WIDTH   = ID_WIDTH_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int ID_TIMEOUT = 1024
) (
  input  logic                          pll_clk,
  input  logic                          reset,
  input  logic                          trig_pulse,
  input  logic                          id_valid,
  input  logic [ID_WIDTH-1:0]           id_data,
  output logic                          capture_start,
  input  logic                          rd_req,
  output logic [ID_WIDTH-1:0]           rd_data,
  input  logic [DEAD_WIDTH-1:0]         dead_time,
  input  logic                          clear_counts,
  output logic                          veto_out,
  output logic                          interrupt,
  output logic [CNT_WIDTH-1:0]          trig_count,
  output logic [CNT_WIDTH-1:0]          lost_count,
  output logic                          err_timeout,
  output ctrl_state_t                   state_dbg,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(ID_TIMEOUT + 1);

  ctrl_state_t           state;
  logic [TW-1:0]         tmo_cnt;
  logic [DEAD_WIDTH-1:0] dead_cnt;

  logic          fifo_push;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push_eff;
  logic          pop_eff;
  logic [FW-1:0] count_nxt;
  logic          full_nxt;
  logic          trig_accept;
  logic          trig_lost;
  logic          timeout_hit;

  assign state_dbg = state;

  // Only the CAPTURE state consumes an ID; late IDs in other states vanish.
  assign fifo_push   = (state == ST_CAPTURE) && id_valid;
  assign pop_eff     = rd_req && !fifo_empty;
  assign push_eff    = fifo_push && (!fifo_full || pop_eff);
  // Occupancy after this cycle, so exits and the interrupt see the effect
  // of a same-cycle push/pop rather than lagging by one cycle.
  assign count_nxt   = fifo_count + FW'(push_eff) - FW'(pop_eff);
  assign full_nxt    = (count_nxt == FW'(FIFO_DEPTH));
  assign trig_accept = (state == ST_IDLE) && trig_pulse && !fifo_full;
  assign trig_lost   = trig_pulse && !trig_accept;
  assign timeout_hit = (state == ST_CAPTURE) && !id_valid &&
                       (tmo_cnt == TW'(ID_TIMEOUT - 1));

  id_fifo #(
    .WIDTH (ID_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_id_fifo (
    .clk   (pll_clk),
    .rst_n (reset),
    .push  (fifo_push),
    .pop   (rd_req),
    .din   (id_data),
    .dout  (rd_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Control FSM with its timers and registered capture_start / veto_out.
  always_ff @(posedge pll_clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      capture_start <= 1'b0;
      veto_out      <= 1'b0;
      tmo_cnt       <= '0;
      dead_cnt      <= '0;
    end else begin
      capture_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (trig_accept) begin
            capture_start <= 1'b1;
            veto_out      <= 1'b1;
            tmo_cnt       <= '0;
            state         <= ST_CAPTURE;
          end else begin
            veto_out <= full_nxt;
          end
        end
        ST_CAPTURE: begin
          // A timeout leaves exactly like a captured ID, just without a push.
          if (id_valid || timeout_hit) begin
            if (dead_time != '0) begin
              dead_cnt <= dead_time - DEAD_WIDTH'(1);
              veto_out <= 1'b1;
              state    <= ST_DEAD;
            end else if (full_nxt) begin
              veto_out <= 1'b1;
              state    <= ST_FULL;
            end else begin
              veto_out <= 1'b0;
              state    <= ST_IDLE;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        ST_DEAD: begin
          if (dead_cnt == '0) begin
            if (full_nxt) begin
              veto_out <= 1'b1;
              state    <= ST_FULL;
            end else begin
              veto_out <= 1'b0;
              state    <= ST_IDLE;
            end
          end else begin
            dead_cnt <= dead_cnt - DEAD_WIDTH'(1);
          end
        end
        ST_FULL: begin
          if (!fifo_full) begin
            veto_out <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            veto_out <= 1'b1;
          end
        end
        default: begin
          veto_out <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  // Accepted and lost trigger counters; a clear wins over an increment.
  always_ff @(posedge pll_clk or negedge reset) begin
    if (!reset) begin
      trig_count <= '0;
      lost_count <= '0;
    end else if (clear_counts) begin
      trig_count <= '0;
      lost_count <= '0;
    end else begin
      if (trig_accept) begin
        trig_count <= sat_inc(trig_count);
      end
      if (trig_lost) begin
        lost_count <= sat_inc(lost_count);
      end
    end
  end

  // Sticky ID-timeout flag, cleared together with the counters.
  always_ff @(posedge pll_clk or negedge reset) begin
    if (!reset) begin
      err_timeout <= 1'b0;
    end else if (clear_counts) begin
      err_timeout <= 1'b0;
    end else if (timeout_hit) begin
      err_timeout <= 1'b1;
    end
  end

  // Interrupt follows FIFO occupancy in the same cycle as rd_data changes.
  always_ff @(posedge pll_clk or negedge reset) begin
    if (!reset) begin
      interrupt <= 1'b0;
    end else begin
      interrupt <= (count_nxt != '0);
    end
  end

endmodule

// File: tb/tb_trigger_readout_ctrl.sv
// Directed bench for trigger_readout_ctrl: a per-cycle vector table for the
// basic accept/readout flow plus hand-written multi-cycle sequences.
module tb_trigger_readout_ctrl;
  import trig_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic        pll_clk = 1'b0;
  logic        reset = 1'b1;
  logic        trig_pulse = 1'b0;
  logic        id_valid = 1'b0;
  logic [15:0] id_data = '0;
  logic        capture_start;
  logic        rd_req = 1'b0;
  logic [15:0] rd_data;
  logic [7:0]  dead_time = '0;
  logic        clear_counts = 1'b0;
  logic        veto_out;
  logic        interrupt;
  logic [15:0] trig_count;
  logic [15:0] lost_count;
  logic        err_timeout;
  ctrl_state_t state_dbg;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  always #5 pll_clk = ~pll_clk;

  trigger_readout_ctrl #(
    .ID_WIDTH   (16),
    .FIFO_DEPTH (4),
    .ID_TIMEOUT (1024)
  ) dut (
    .pll_clk       (pll_clk),
    .reset         (reset),
    .trig_pulse    (trig_pulse),
    .id_valid      (id_valid),
    .id_data       (id_data),
    .capture_start (capture_start),
    .rd_req        (rd_req),
    .rd_data       (rd_data),
    .dead_time     (dead_time),
    .clear_counts  (clear_counts),
    .veto_out      (veto_out),
    .interrupt     (interrupt),
    .trig_count    (trig_count),
    .lost_count    (lost_count),
    .err_timeout   (err_timeout),
    .state_dbg     (state_dbg),
    .fifo_count    (fifo_count)
  );

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge pll_clk);
    #1;
  endtask

  task automatic clear_inputs();
    trig_pulse   = 1'b0;
    id_valid     = 1'b0;
    id_data      = '0;
    rd_req       = 1'b0;
    clear_counts = 1'b0;
  endtask

  // Asynchronous reset between the clock edges, with reset-state checks.
  task automatic do_reset(input string tag);
    @(posedge pll_clk);
    #3;
    reset = 1'b0;
    clear_inputs();
    #1;
    chk({tag, "_rst_rd_data"}, 32'(rd_data), 32'h0);
    chk({tag, "_rst_veto"}, 32'(veto_out), 32'h0);
    chk({tag, "_rst_irq"}, 32'(interrupt), 32'h0);
    chk({tag, "_rst_cs"}, 32'(capture_start), 32'h0);
    chk({tag, "_rst_trig_cnt"}, 32'(trig_count), 32'h0);
    chk({tag, "_rst_lost_cnt"}, 32'(lost_count), 32'h0);
    chk({tag, "_rst_err"}, 32'(err_timeout), 32'h0);
    chk({tag, "_rst_state"}, 32'(state_dbg), 32'(ST_IDLE));
    chk({tag, "_rst_count"}, 32'(fifo_count), 32'h0);
    step();
    step();
    reset = 1'b1;
  endtask

  // Trigger, wait one cycle, deliver an ID, then one idle cycle.
  task automatic accept_id(input logic [15:0] id);
    trig_pulse = 1'b1;
    step();
    trig_pulse = 1'b0;
    step();
    id_valid = 1'b1;
    id_data  = id;
    step();
    id_valid = 1'b0;
    id_data  = '0;
    step();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        trig;
    logic        idv;
    logic [15:0] idd;
    logic        rd;
    logic        exp_cs;
    logic        exp_veto;
    logic        exp_irq;
    logic [15:0] exp_rd;
    logic [1:0]  exp_st;
  } vec_t;

  vec_t vecs[10];

  initial begin
    // trigger at row 0, ID arrives five cycles after capture_start (row 6)
    vecs[0] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 2'd1};
    vecs[1] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd1};
    vecs[2] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd1};
    vecs[3] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd1};
    vecs[4] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd1};
    vecs[5] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd1};
    vecs[6] = '{1'b0, 1'b1, 16'hA5C3, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA5C3, 2'd0};
    vecs[7] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA5C3, 2'd0};
    vecs[8] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd0};
    vecs[9] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd0};

    // ---- basic accept and readout, dead_time 0 ----
    dead_time = 8'd0;
    do_reset("basic");
    for (int i = 0; i < 10; i++) begin
      trig_pulse = vecs[i].trig;
      id_valid   = vecs[i].idv;
      id_data    = vecs[i].idd;
      rd_req     = vecs[i].rd;
      step();
      chk($sformatf("vec%0d_cs", i), 32'(capture_start), 32'(vecs[i].exp_cs));
      chk($sformatf("vec%0d_veto", i), 32'(veto_out), 32'(vecs[i].exp_veto));
      chk($sformatf("vec%0d_irq", i), 32'(interrupt), 32'(vecs[i].exp_irq));
      chk($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].exp_rd));
      chk($sformatf("vec%0d_state", i), 32'(state_dbg), 32'(vecs[i].exp_st));
    end
    clear_inputs();
    chk("basic_trig_cnt", 32'(trig_count), 32'd1);
    chk("basic_lost_cnt", 32'(lost_count), 32'd0);

    // ---- dead time of 10 cycles with a trigger inside it ----
    dead_time = 8'd10;
    do_reset("dead");
    trig_pulse = 1'b1;
    step();
    trig_pulse = 1'b0;
    step();
    id_valid = 1'b1;
    id_data  = 16'h0011;
    step();
    id_valid = 1'b0;
    id_data  = '0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("dead_veto_c%0d", i), 32'(veto_out), 32'h1);
      chk($sformatf("dead_state_c%0d", i), 32'(state_dbg), 32'(ST_DEAD));
      if (i == 3) trig_pulse = 1'b1;
      step();
      trig_pulse = 1'b0;
    end
    chk("dead_veto_end", 32'(veto_out), 32'h0);
    chk("dead_state_end", 32'(state_dbg), 32'(ST_IDLE));
    chk("dead_lost_cnt", 32'(lost_count), 32'd1);
    chk("dead_trig_cnt", 32'(trig_count), 32'd1);
    chk("dead_rd_data", 32'(rd_data), 32'h0011);
    chk("dead_irq", 32'(interrupt), 32'h1);

    // ---- fill the FIFO, overflow trigger, one read ----
    dead_time = 8'd0;
    do_reset("full");
    for (int i = 1; i <= 4; i++) accept_id(16'(i));
    chk("full_state", 32'(state_dbg), 32'(ST_FULL));
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_head", 32'(rd_data), 32'h0001);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("full_veto_hold%0d", i), 32'(veto_out), 32'h1);
    end
    trig_pulse = 1'b1;
    step();
    trig_pulse = 1'b0;
    chk("full_lost_cnt", 32'(lost_count), 32'd1);
    chk("full_trig_cnt", 32'(trig_count), 32'd4);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    chk("full_rd_data_2", 32'(rd_data), 32'h0002);
    chk("full_veto_r1", 32'(veto_out), 32'h1);
    step();
    chk("full_veto_r2", 32'(veto_out), 32'h0);
    chk("full_state_r2", 32'(state_dbg), 32'(ST_IDLE));
    chk("full_count_r2", 32'(fifo_count), 32'd3);

    // ---- ID timeout ----
    do_reset("tmo");
    trig_pulse = 1'b1;
    step();
    trig_pulse = 1'b0;
    for (int i = 0; i < 1023; i++) step();
    chk("tmo_err_c1024", 32'(err_timeout), 32'h0);
    chk("tmo_state_c1024", 32'(state_dbg), 32'(ST_CAPTURE));
    step();
    chk("tmo_err_c1025", 32'(err_timeout), 32'h1);
    chk("tmo_state_c1025", 32'(state_dbg), 32'(ST_IDLE));
    chk("tmo_count", 32'(fifo_count), 32'd0);
    chk("tmo_irq", 32'(interrupt), 32'h0);
    chk("tmo_veto", 32'(veto_out), 32'h0);
    id_valid = 1'b1;
    id_data  = 16'hBEEF;
    step();
    id_valid = 1'b0;
    chk("tmo_late_id_count", 32'(fifo_count), 32'd0);
    clear_counts = 1'b1;
    step();
    clear_counts = 1'b0;
    chk("tmo_clear_err", 32'(err_timeout), 32'h0);
    chk("tmo_clear_trig", 32'(trig_count), 32'd0);

    // ---- push and pop in the same cycle ----
    do_reset("pp");
    trig_pulse = 1'b1;
    step();
    trig_pulse = 1'b0;
    step();
    id_valid = 1'b1;
    id_data  = 16'h0042;
    rd_req   = 1'b1;
    step();
    clear_inputs();
    chk("pp_empty_count", 32'(fifo_count), 32'd1);
    chk("pp_empty_rd_data", 32'(rd_data), 32'h0042);
    trig_pulse = 1'b1;
    step();
    trig_pulse = 1'b0;
    step();
    id_valid = 1'b1;
    id_data  = 16'h0007;
    rd_req   = 1'b1;
    step();
    clear_inputs();
    chk("pp_count", 32'(fifo_count), 32'd1);
    chk("pp_rd_data", 32'(rd_data), 32'h0007);
    chk("pp_irq", 32'(interrupt), 32'h1);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    chk("pp_drain_rd_data", 32'(rd_data), 32'h0);
    chk("pp_drain_irq", 32'(interrupt), 32'h0);

    // ---- reset in the middle of CAPTURE, late ID afterwards ----
    do_reset("midrst");
    trig_pulse = 1'b1;
    step();
    trig_pulse = 1'b0;
    chk("midrst_pre_state", 32'(state_dbg), 32'(ST_CAPTURE));
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_async_veto", 32'(veto_out), 32'h0);
    chk("midrst_async_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("midrst_async_trig", 32'(trig_count), 32'd0);
    step();
    reset = 1'b1;
    step();
    step();
    id_valid = 1'b1;
    id_data  = 16'h1234;
    step();
    clear_inputs();
    chk("midrst_count", 32'(fifo_count), 32'd0);
    chk("midrst_rd_data", 32'(rd_data), 32'h0);
    chk("midrst_irq", 32'(interrupt), 32'h0);
    chk("midrst_veto", 32'(veto_out), 32'h0);
    chk("midrst_state", 32'(state_dbg), 32'(ST_IDLE));

    // ---- lost counter saturation and clear priority ----
    do_reset("sat");
    trig_pulse = 1'b1;
    id_valid   = 1'b1;
    id_data    = 16'h00AA;
    for (int i = 0; i < 65545; i++) step();
    chk("sat_lost_cnt", 32'(lost_count), 32'hFFFF);
    chk("sat_trig_cnt", 32'(trig_count), 32'd4);
    chk("sat_state", 32'(state_dbg), 32'(ST_FULL));
    clear_counts = 1'b1;
    step();
    clear_counts = 1'b0;
    chk("sat_clear_prio", 32'(lost_count), 32'd0);
    step();
    chk("sat_after_clear", 32'(lost_count), 32'd1);
    clear_inputs();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
